// File: rtl/sdram_cmd_controller.sv
// Command-level controller for one 4-bank x16 SDR SDRAM: edge-detected ASCII user
// commands become registered one-cycle SDRAM pin commands plus read/write burst data moves.
module sdram_cmd_controller #(
  parameter int INIT_NOP_CYCLES = 20,
  parameter int REF_GAP         = 8
) (
  input  logic         clk_crontroller,
  input  logic         reset,
  input  logic [239:0] Command,
  input  logic [21:0]  Address,
  input  logic [7:0]   Burst_length,
  input  logic [7:0]   Accessing_mode,
  input  logic [7:0]   CAS_latency,
  input  logic [39:0]  Single_write_mode,
  input  logic [15:0]  DQ_SDRAM_CONT,
  input  logic [15:0]  DQ_USER_CONT,
  output logic [11:0]  A,
  output logic [1:0]   BS,
  output logic         clk_sdram,
  output logic         CKE,
  output logic         CS,
  output logic         RAS,
  output logic         CAS,
  output logic         WE,
  output logic         LDQM,
  output logic         UDQM,
  output logic [15:0]  DQ_CONT_SDRAM,
  output logic [15:0]  DQ_CONT_USER,
  output logic         Vcc,
  output logic         VccQ,
  output logic         Vss,
  output logic         VssQ,
  output logic [1:0]   fsm_state_o
);

  typedef enum logic [1:0] {ST_INIT = 2'd0, ST_IDLE = 2'd1, ST_PD = 2'd2} state_t;

  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_READ = 4'b0101, C_WRITE = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000, C_DESEL = 4'b1111;

  localparam logic [239:0] S_POWER_UP = 240'("power_up");
  localparam logic [239:0] S_ACT      = 240'("bank_activate");
  localparam logic [239:0] S_READ     = 240'("read");
  localparam logic [239:0] S_WRITE    = 240'("write");
  localparam logic [239:0] S_PRE      = 240'("bank_precharge");
  localparam logic [239:0] S_REF      = 240'("auto_refresh");
  localparam logic [239:0] S_MRS      = 240'("mode_register_set");
  localparam logic [239:0] S_END      = 240'("end_task");

  localparam logic [15:0] T_PRE  = 16'(INIT_NOP_CYCLES);
  localparam logic [15:0] T_REF1 = 16'(INIT_NOP_CYCLES + REF_GAP);
  localparam logic [15:0] T_REF2 = 16'(INIT_NOP_CYCLES + 2 * REF_GAP);
  localparam logic [15:0] T_MRS  = 16'(INIT_NOP_CYCLES + 3 * REF_GAP);

  state_t         state_q, state_d;
  logic [15:0]    cnt_q, cnt_d;
  logic [239:0]   cmd_prev_q, cmd_prev_d;
  logic [3:0]     bank_open_q, bank_open_d;
  logic           cke_q, cke_d;
  logic [3:0]     cmd_q, cmd_d;
  logic [11:0]    a_q, a_d;
  logic [1:0]     bs_q, bs_d;
  logic           dqm_q, dqm_d;
  logic [15:0]    dq_sdram_q, dq_sdram_d;
  logic [15:0]    dq_user_q, dq_user_d;
  logic [8:0]     rd_left_q, rd_left_d;
  logic [1:0]     rd_dly_q, rd_dly_d;
  logic [8:0]     wr_left_q, wr_left_d;

  logic [1:0]     bank;
  logic [8:0]     bl_val, wr_bl;
  logic [2:0]     bl_code;
  logic [1:0]     cl_val;
  logic           bt, single_wr, cmd_new;
  logic           start_rd, start_wr, kill;
  logic [11:0]    mrs_val;

  assign bank = Address[21:20];

  always_comb begin
    bl_val  = 9'd1;
    bl_code = 3'b000;
    case (Burst_length)
      "2":     begin bl_val = 9'd2;   bl_code = 3'b001; end
      "4":     begin bl_val = 9'd4;   bl_code = 3'b010; end
      "8":     begin bl_val = 9'd8;   bl_code = 3'b011; end
      "f":     begin bl_val = 9'd256; bl_code = 3'b111; end
      default: begin bl_val = 9'd1;   bl_code = 3'b000; end
    endcase
    cl_val    = (CAS_latency == "3") ? 2'd3 : 2'd2;
    bt        = (Accessing_mode == "i");
    single_wr = (Single_write_mode == "br&sw");
    wr_bl     = single_wr ? 9'd1 : bl_val;
    mrs_val   = {2'b00, single_wr, 2'b00, 1'b0, cl_val, bt, bl_code};
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cmd_prev_d  = Command;
    bank_open_d = bank_open_q;
    cke_d       = cke_q;
    cmd_d       = C_NOP;
    a_d         = a_q;
    bs_d        = bs_q;
    dqm_d       = 1'b1;
    dq_sdram_d  = dq_sdram_q;
    dq_user_d   = dq_user_q;
    rd_left_d   = rd_left_q;
    rd_dly_d    = rd_dly_q;
    wr_left_d   = wr_left_q;
    cmd_new     = (Command != cmd_prev_q);
    start_rd    = 1'b0;
    start_wr    = 1'b0;
    kill        = 1'b0;

    case (state_q)
      ST_INIT: begin
        // Commands arriving here are consumed by cmd_prev_d and therefore ignored.
        cke_d = 1'b1;
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == T_PRE) begin
          cmd_d       = C_PRE;
          a_d         = 12'h400;
          bs_d        = 2'b00;
          bank_open_d = 4'b0000;
        end else if (cnt_q == T_REF1 || cnt_q == T_REF2) begin
          cmd_d = C_REF;
        end else if (cnt_q == T_MRS) begin
          cmd_d   = C_MRS;
          a_d     = mrs_val;
          bs_d    = 2'b00;
          state_d = ST_IDLE;
          cnt_d   = 16'd0;
        end
      end
      ST_IDLE: begin
        cke_d = 1'b1;
        if (cmd_new) begin
          case (Command)
            S_POWER_UP: begin
              state_d     = ST_INIT;
              cnt_d       = 16'd0;
              bank_open_d = 4'b0000;
              kill        = 1'b1;
            end
            S_ACT: begin
              cmd_d             = C_ACT;
              bs_d              = bank;
              a_d               = Address[19:8];
              bank_open_d[bank] = 1'b1;
            end
            S_READ: if (bank_open_q[bank]) begin
              cmd_d    = C_READ;
              bs_d     = bank;
              a_d      = {4'b0000, Address[7:0]};
              start_rd = 1'b1;
            end
            S_WRITE: if (bank_open_q[bank]) begin
              cmd_d    = C_WRITE;
              bs_d     = bank;
              a_d      = {4'b0000, Address[7:0]};
              start_wr = 1'b1;
            end
            S_PRE: begin
              cmd_d             = C_PRE;
              bs_d              = bank;
              a_d               = 12'h000;
              bank_open_d[bank] = 1'b0;
              kill              = 1'b1;
            end
            S_REF: if (bank_open_q == 4'b0000) cmd_d = C_REF;
            S_MRS: begin
              cmd_d = C_MRS;
              a_d   = mrs_val;
              bs_d  = 2'b00;
            end
            S_END: begin
              cmd_d       = C_PRE;
              a_d         = 12'h400;
              bs_d        = 2'b00;
              bank_open_d = 4'b0000;
              state_d     = ST_PD;
              kill        = 1'b1;
            end
            default: cmd_d = C_NOP;
          endcase
        end
      end
      ST_PD: begin
        cke_d = 1'b0;
        cmd_d = C_DESEL;
        if (cmd_new && Command == S_POWER_UP) begin
          cke_d   = 1'b1;
          cmd_d   = C_NOP;
          state_d = ST_INIT;
          cnt_d   = 16'd0;
        end
      end
      default: state_d = ST_INIT;
    endcase

    // A new READ/WRITE/PRE replaces any running burst on the very edge it issues.
    if (start_rd) begin
      rd_left_d = bl_val;
      rd_dly_d  = cl_val - 2'd1;
      wr_left_d = 9'd0;
    end else if (start_wr) begin
      rd_left_d  = 9'd0;
      wr_left_d  = wr_bl - 9'd1;
      dq_sdram_d = DQ_USER_CONT;
      dqm_d      = 1'b0;
    end else if (kill) begin
      rd_left_d = 9'd0;
      wr_left_d = 9'd0;
    end else begin
      if (rd_left_q != 9'd0) begin
        if (rd_dly_q != 2'd0) begin
          rd_dly_d = rd_dly_q - 2'd1;
        end else begin
          dq_user_d = DQ_SDRAM_CONT;
          rd_left_d = rd_left_q - 9'd1;
          dqm_d     = 1'b0;
        end
      end
      if (wr_left_q != 9'd0) begin
        dq_sdram_d = DQ_USER_CONT;
        wr_left_d  = wr_left_q - 9'd1;
        dqm_d      = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_crontroller or posedge reset) begin
    if (reset) begin
      state_q     <= ST_INIT;
      cnt_q       <= 16'd0;
      cmd_prev_q  <= 240'd0;
      bank_open_q <= 4'b0000;
      cke_q       <= 1'b0;
      cmd_q       <= C_DESEL;
      a_q         <= 12'h000;
      bs_q        <= 2'b00;
      dqm_q       <= 1'b1;
      dq_sdram_q  <= 16'h0000;
      dq_user_q   <= 16'h0000;
      rd_left_q   <= 9'd0;
      rd_dly_q    <= 2'd0;
      wr_left_q   <= 9'd0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cmd_prev_q  <= cmd_prev_d;
      bank_open_q <= bank_open_d;
      cke_q       <= cke_d;
      cmd_q       <= cmd_d;
      a_q         <= a_d;
      bs_q        <= bs_d;
      dqm_q       <= dqm_d;
      dq_sdram_q  <= dq_sdram_d;
      dq_user_q   <= dq_user_d;
      rd_left_q   <= rd_left_d;
      rd_dly_q    <= rd_dly_d;
      wr_left_q   <= wr_left_d;
    end
  end

  assign {CS, RAS, CAS, WE} = cmd_q;
  assign CKE           = cke_q;
  assign A             = a_q;
  assign BS            = bs_q;
  assign LDQM          = dqm_q;
  assign UDQM          = dqm_q;
  assign DQ_CONT_SDRAM = dq_sdram_q;
  assign DQ_CONT_USER  = dq_user_q;
  assign clk_sdram     = clk_crontroller;
  assign Vcc           = 1'b1;
  assign VccQ          = 1'b1;
  assign Vss           = 1'b0;
  assign VssQ          = 1'b0;
  assign fsm_state_o   = state_q;

endmodule

// File: tb/tb_sdram_cmd_controller.sv
// Randomized bench for sdram_cmd_controller: every cycle is compared against a
// cycle-window reference model of the command, mask and data behaviour.
module tb_sdram_cmd_controller;

  localparam int NOPS = 20;
  localparam int GAP  = 8;

  localparam logic [3:0] C_NOP = 4'b0111, C_ACT = 4'b0011, C_READ = 4'b0101, C_WRITE = 4'b0100;
  localparam logic [3:0] C_PRE = 4'b0010, C_REF = 4'b0001, C_MRS = 4'b0000, C_DES = 4'b1111;

  localparam logic [239:0] S_PWR   = 240'("power_up");
  localparam logic [239:0] S_NOP   = 240'("no_operation");
  localparam logic [239:0] S_ACT   = 240'("bank_activate");
  localparam logic [239:0] S_READ  = 240'("read");
  localparam logic [239:0] S_WRITE = 240'("write");
  localparam logic [239:0] S_PRE   = 240'("bank_precharge");
  localparam logic [239:0] S_REF   = 240'("auto_refresh");
  localparam logic [239:0] S_MRS   = 240'("mode_register_set");
  localparam logic [239:0] S_END   = 240'("end_task");
  localparam logic [239:0] S_BOGUS = 240'("bogus_cmd");

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [239:0] Command;
  logic [21:0]  Address;
  logic [7:0]   Burst_length, Accessing_mode, CAS_latency;
  logic [39:0]  Single_write_mode;
  logic [15:0]  DQ_SDRAM_CONT, DQ_USER_CONT;
  logic [11:0]  A;
  logic [1:0]   BS;
  logic         clk_sdram, CKE, CS, RAS, CAS, WE, LDQM, UDQM;
  logic [15:0]  DQ_CONT_SDRAM, DQ_CONT_USER;
  logic         Vcc, VccQ, Vss, VssQ;
  logic [1:0]   fsm_state;

  sdram_cmd_controller #(.INIT_NOP_CYCLES(NOPS), .REF_GAP(GAP)) dut (
    .clk_crontroller(clk), .reset(rst), .Command(Command), .Address(Address),
    .Burst_length(Burst_length), .Accessing_mode(Accessing_mode), .CAS_latency(CAS_latency),
    .Single_write_mode(Single_write_mode), .DQ_SDRAM_CONT(DQ_SDRAM_CONT), .DQ_USER_CONT(DQ_USER_CONT),
    .A(A), .BS(BS), .clk_sdram(clk_sdram), .CKE(CKE), .CS(CS), .RAS(RAS), .CAS(CAS), .WE(WE),
    .LDQM(LDQM), .UDQM(UDQM), .DQ_CONT_SDRAM(DQ_CONT_SDRAM), .DQ_CONT_USER(DQ_CONT_USER),
    .Vcc(Vcc), .VccQ(VccQ), .Vss(Vss), .VssQ(VssQ), .fsm_state_o(fsm_state)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // reference model: controller mode, open banks and burst windows in absolute cycles
  typedef enum int {M_INIT, M_IDLE, M_PD} m_state_t;
  m_state_t     m_state = M_INIT;
  int           init_base = 0;
  logic [239:0] m_prev = '0;
  logic [3:0]   m_open = '0;
  int           rd_lo = 1, rd_hi = 0, wr_lo = 1, wr_hi = 0;
  logic [15:0]  m_user = '0, m_sdram = '0;
  logic [15:0]  exp_q[$];

  function automatic int f_bl();
    case (Burst_length)
      "2": return 2;
      "4": return 4;
      "8": return 8;
      "f": return 256;
      default: return 1;
    endcase
  endfunction

  function automatic int f_cl();
    return (CAS_latency == "3") ? 3 : 2;
  endfunction

  function automatic logic [11:0] f_mrs();
    logic [2:0] blc;
    case (Burst_length)
      "2": blc = 3'b001;
      "4": blc = 3'b010;
      "8": blc = 3'b011;
      "f": blc = 3'b111;
      default: blc = 3'b000;
    endcase
    return {2'b00, Single_write_mode == "br&sw", 2'b00,
            (CAS_latency == "3") ? 3'b011 : 3'b010, Accessing_mode == "i", blc};
  endfunction

  task automatic kill_bursts();
    rd_lo = 1; rd_hi = 0; wr_lo = 1; wr_hi = 0;
  endtask

  task automatic model_edge(output logic [3:0] e_cmd, output logic e_cke, output logic [11:0] e_a,
                            output logic [1:0] e_bs, output bit ck_a, output bit ck_a10, output bit ck_bs);
    bit changed;
    int k;
    int b;
    changed = (Command !== m_prev);
    m_prev  = Command;
    e_cmd = C_NOP; e_cke = 1'b1; e_a = '0; e_bs = '0; ck_a = 0; ck_a10 = 0; ck_bs = 0;
    b = int'(Address[21:20]);
    case (m_state)
      M_INIT: begin
        k = cyc - init_base;
        if (k == NOPS + 1) begin
          e_cmd = C_PRE; e_a = 12'h400; ck_a10 = 1; m_open = '0;
        end else if (k == NOPS + 1 + GAP || k == NOPS + 1 + 2 * GAP) begin
          e_cmd = C_REF;
        end else if (k == NOPS + 1 + 3 * GAP) begin
          e_cmd = C_MRS; e_a = f_mrs(); ck_a = 1; m_state = M_IDLE;
        end
      end
      M_PD: begin
        e_cke = 1'b0; e_cmd = C_DES;
        if (changed && Command == S_PWR) begin
          e_cke = 1'b1; e_cmd = C_NOP; m_state = M_INIT; init_base = cyc;
        end
      end
      default: if (changed) begin
        if (Command == S_PWR) begin
          m_state = M_INIT; init_base = cyc; m_open = '0; kill_bursts();
        end else if (Command == S_ACT) begin
          e_cmd = C_ACT; e_a = Address[19:8]; e_bs = Address[21:20]; ck_a = 1; ck_bs = 1; m_open[b] = 1'b1;
        end else if (Command == S_READ && m_open[b]) begin
          kill_bursts();
          e_cmd = C_READ; e_a = {4'h0, Address[7:0]}; e_bs = Address[21:20]; ck_a = 1; ck_bs = 1;
          rd_lo = cyc + f_cl(); rd_hi = rd_lo + f_bl() - 1;
        end else if (Command == S_WRITE && m_open[b]) begin
          kill_bursts();
          e_cmd = C_WRITE; e_a = {4'h0, Address[7:0]}; e_bs = Address[21:20]; ck_a = 1; ck_bs = 1;
          wr_lo = cyc; wr_hi = cyc + ((Single_write_mode == "br&sw") ? 1 : f_bl()) - 1;
        end else if (Command == S_PRE) begin
          kill_bursts();
          e_cmd = C_PRE; e_a = 12'h000; e_bs = Address[21:20]; ck_a10 = 1; ck_bs = 1; m_open[b] = 1'b0;
        end else if (Command == S_REF && m_open == 4'b0000) begin
          e_cmd = C_REF;
        end else if (Command == S_MRS) begin
          e_cmd = C_MRS; e_a = f_mrs(); ck_a = 1;
        end else if (Command == S_END) begin
          kill_bursts();
          e_cmd = C_PRE; e_a = 12'h400; ck_a10 = 1; m_open = '0; m_state = M_PD;
        end
      end
    endcase
    if (cyc >= rd_lo && cyc <= rd_hi) m_user = DQ_SDRAM_CONT;
    if (cyc >= wr_lo && cyc <= wr_hi) exp_q.push_back(DQ_USER_CONT);
  endtask

  // driver: one clock of stimulus followed by a full output comparison
  task automatic step(input logic [239:0] cmd, input logic [21:0] addr);
    logic [3:0]  e_cmd;
    logic        e_cke, e_dqm;
    logic [11:0] e_a;
    logic [1:0]  e_bs;
    bit          ck_a, ck_a10, ck_bs;
    @(negedge clk);
    Command       = cmd;
    Address       = addr;
    DQ_SDRAM_CONT = 16'($urandom);
    DQ_USER_CONT  = 16'($urandom);
    @(posedge clk);
    cyc++;
    model_edge(e_cmd, e_cke, e_a, e_bs, ck_a, ck_a10, ck_bs);
    e_dqm = !((cyc >= rd_lo && cyc <= rd_hi) || (cyc >= wr_lo && cyc <= wr_hi));
    if (exp_q.size() > 0) m_sdram = exp_q.pop_front();
    #1;
    check("cmd", {CS, RAS, CAS, WE}, e_cmd);
    check("cke", CKE, e_cke);
    check("ldqm", LDQM, e_dqm);
    check("udqm", UDQM, e_dqm);
    check("dq_user", DQ_CONT_USER, m_user);
    check("dq_sdram", DQ_CONT_SDRAM, m_sdram);
    if (ck_a)   check("a", A, e_a);
    if (ck_a10) check("a10", A[10], e_a[10]);
    if (ck_bs)  check("bs", BS, e_bs);
  endtask

  task automatic check_reset(input string pfx);
    check({pfx, "_cke"}, CKE, 1'b0);
    check({pfx, "_cmd"}, {CS, RAS, CAS, WE}, 4'b1111);
    check({pfx, "_a"}, A, 12'h000);
    check({pfx, "_bs"}, BS, 2'b00);
    check({pfx, "_dqm"}, {LDQM, UDQM}, 2'b11);
    check({pfx, "_dq_sdram"}, DQ_CONT_SDRAM, 16'h0000);
    check({pfx, "_dq_user"}, DQ_CONT_USER, 16'h0000);
  endtask

  logic [7:0]   bl_tab [4] = '{8'h31, 8'h32, 8'h34, 8'h38};
  logic [239:0] pool [10]  = '{S_ACT, S_ACT, S_READ, S_READ, S_WRITE, S_PRE, S_REF, S_MRS, S_NOP, S_BOGUS};

  task automatic run_init(input string tag);
    bit          seen;
    logic [11:0] seen_a;
    seen = 0; seen_a = '0;
    for (int i = 0; i < 50; i++) begin
      step(Command, Address);
      if ({CS, RAS, CAS, WE} == C_MRS) begin seen = 1; seen_a = A; end
    end
    check({tag, "_mrs_seen"}, seen, 1'b1);
    check({tag, "_mrs_a"}, seen_a, 12'h022);
  endtask

  localparam logic [21:0] DIR_ADDR = {2'b00, 12'haf4, 8'h5d};

  initial begin
    rst = 1'b1;
    Command = '0; Address = '0;
    Burst_length = "4"; Accessing_mode = "s"; CAS_latency = "2"; Single_write_mode = "br&bw";
    DQ_SDRAM_CONT = '0; DQ_USER_CONT = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset("rst");
    check("supplies", {Vcc, VccQ, Vss, VssQ}, 4'b1100);
    check("clk_sdram_lo", clk_sdram, clk);
    @(posedge clk);
    #1 check("clk_sdram_hi", clk_sdram, clk);
    #1 rst = 1'b0;

    // initialisation, then the directed activate / read / write / drop sequence
    Command = S_PWR;
    run_init("init");
    step(S_ACT, DIR_ADDR);
    repeat (2) step(S_NOP, DIR_ADDR);
    step(S_READ, DIR_ADDR);
    repeat (6) step(S_NOP, DIR_ADDR);
    step(S_WRITE, DIR_ADDR);
    repeat (6) step(S_NOP, DIR_ADDR);
    step(S_PRE, DIR_ADDR);
    step(S_NOP, DIR_ADDR);
    step(S_READ, DIR_ADDR);
    repeat (2) step(S_NOP, DIR_ADDR);

    // randomized command mix with occasional mode changes
    for (int n = 0; n < 200; n++) begin
      logic [239:0] c;
      logic [21:0]  ad;
      int           sel;
      if ($urandom_range(0, 7) == 0) begin
        sel = $urandom_range(0, 8);
        Burst_length      = (sel == 8) ? 8'h66 : bl_tab[sel % 4];
        Accessing_mode    = ($urandom_range(0, 1) == 1) ? 8'h69 : 8'h73;
        CAS_latency       = ($urandom_range(0, 1) == 1) ? 8'h33 : 8'h32;
        Single_write_mode = ($urandom_range(0, 2) == 0) ? 40'("br&sw") : 40'("br&bw");
      end
      c  = pool[$urandom_range(0, 9)];
      ad = {2'($urandom_range(0, 3)), 12'($urandom), 8'($urandom)};
      step(c, ad);
      repeat ($urandom_range(0, 6)) step(c, ad);
    end

    // power-down and wake-up
    step(S_END, DIR_ADDR);
    repeat (4) step(S_END, DIR_ADDR);
    Burst_length = "4"; Accessing_mode = "s"; CAS_latency = "2"; Single_write_mode = "br&bw";
    step(S_PWR, DIR_ADDR);
    run_init("wake");

    // reset in the middle of a read burst
    Burst_length = "8";
    step(S_ACT, {2'b01, 12'h123, 8'h40});
    step(S_READ, {2'b01, 12'h123, 8'h40});
    repeat (3) step(S_NOP, {2'b01, 12'h123, 8'h40});
    #2 rst = 1'b1;
    #1 check_reset("midrst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
